// File: rtl/inst_rom_arbiter_pkg.sv
// Shared defines for the instruction-ROM port: bus widths, chip-enable levels,
// the zero word and the arbiter state encodings.
package inst_rom_arbiter_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  localparam int StarveCntW = 8;

  typedef enum logic {
    ArbStateNormal = 1'b0,
    ArbStateLock   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/inst_rom_arbiter.sv
// Shares the instruction ROM read port between the fetch stage and the debug
// reader; grants are combinational, responses are registered one cycle later.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = InstAddrBus,
  parameter int DATA_W       = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              flush,
  output logic              f_gnt,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_inst,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_inst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(STARVE_LIMIT);

  arb_state_e            state;
  logic [StarveCntW-1:0] starve_cnt;

  logic f_sel_p0;
  logic d_sel_p0;

  logic              f_vld_p1;
  logic              d_vld_p1;
  logic [DATA_W-1:0] f_inst_p1;
  logic [DATA_W-1:0] d_inst_p1;

  function automatic logic [StarveCntW-1:0] sat_inc(
    input logic [StarveCntW-1:0] v,
    input logic [StarveCntW-1:0] lim
  );
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  // ---- p0: grant selection and ROM drive ----
  // Grants are held off while rst is low so the ROM sees no access during reset.
  always_comb begin
    f_sel_p0 = 1'b0;
    d_sel_p0 = 1'b0;
    if (rst) begin
      if (state == ArbStateLock) begin
        d_sel_p0 = d_req;
      end else if (d_req && (starve_cnt == StarveMax)) begin
        d_sel_p0 = 1'b1;
      end else if (f_req && !flush) begin
        f_sel_p0 = 1'b1;
      end else if (d_req) begin
        d_sel_p0 = 1'b1;
      end
    end
  end

  always_comb begin
    rom_ce   = ChipDisable;
    rom_addr = '0;
    if (f_sel_p0) begin
      rom_ce   = ChipEnable;
      rom_addr = f_addr;
    end else if (d_sel_p0) begin
      rom_ce   = ChipEnable;
      rom_addr = d_addr;
    end
  end

  assign f_gnt = f_sel_p0;
  assign d_gnt = d_sel_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ArbStateNormal;
      starve_cnt <= '0;
    end else begin
      case (state)
        ArbStateNormal: if (d_sel_p0 && d_lock) state <= ArbStateLock;
        ArbStateLock:   if (!d_lock)            state <= ArbStateNormal;
        default:                                state <= ArbStateNormal;
      endcase
      if (d_sel_p0 || !d_req) begin
        starve_cnt <= '0;
      end else if (f_sel_p0) begin
        starve_cnt <= sat_inc(starve_cnt, StarveMax);
      end
    end
  end

  // ---- p1: registered responses, one cycle after the grant ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_vld_p1  <= 1'b0;
      d_vld_p1  <= 1'b0;
      f_inst_p1 <= DATA_W'(ZeroWord);
      d_inst_p1 <= DATA_W'(ZeroWord);
    end else begin
      f_vld_p1 <= f_sel_p0;
      d_vld_p1 <= d_sel_p0;
      if (f_sel_p0) f_inst_p1 <= rom_inst;
      if (d_sel_p0) d_inst_p1 <= rom_inst;
    end
  end

  assign f_rsp_valid = f_vld_p1;
  assign f_rsp_inst  = f_inst_p1;
  assign d_rsp_valid = d_vld_p1;
  assign d_rsp_inst  = d_inst_p1;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter with a behavioural ROM whose word at
// byte address A is 0xCAFE0000 | (A >> 2).
module tb_inst_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        flush;
  logic        f_gnt;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_inst;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_lock;
  logic        d_gnt;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_inst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  int n_tests;
  int n_fail;

  inst_rom_arbiter #(.STARVE_LIMIT(8), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .flush(flush), .f_gnt(f_gnt),
    .f_rsp_valid(f_rsp_valid), .f_rsp_inst(f_rsp_inst),
    .d_req(d_req), .d_addr(d_addr), .d_lock(d_lock), .d_gnt(d_gnt),
    .d_rsp_valid(d_rsp_valid), .d_rsp_inst(d_rsp_inst),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  always_comb rom_inst = rom_ce ? (32'hCAFE_0000 | {2'b00, rom_addr[31:2]}) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        flush;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_lock;
    logic        x_f_gnt;
    logic        x_d_gnt;
    logic        x_ce;
    logic [31:0] x_addr;
    logic        x_fv;
    logic [31:0] x_finst;
    logic        x_dv;
    logic [31:0] x_dinst;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic fl,
                       input logic dr, input logic [31:0] da, input logic dl);
    f_req  = fr;
    f_addr = fa;
    flush  = fl;
    d_req  = dr;
    d_addr = da;
    d_lock = dl;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0);

    //            f_req f_addr    fl  d_req d_addr   lk | fg  dg  ce  rom_addr  fv  f_inst        dv  d_inst
    vecs[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'hCAFE_0000, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'hCAFE_0002, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'hCAFE_0002, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'hCAFE_0002, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h10, 1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'hCAFE_0002, 1'b1, 32'hCAFE_0010};
    vecs[7]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'hCAFE_0004, 1'b0, 32'hCAFE_0010};
    vecs[8]  = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 1'b1, 1'b1, 32'h48, 1'b0, 32'hCAFE_0004, 1'b0, 32'hCAFE_0010};
    vecs[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'hCAFE_0004, 1'b1, 32'hCAFE_0012};
    vecs[10] = '{1'b1, 32'h20, 1'b0, 1'b1, 32'h50, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'hCAFE_0004, 1'b0, 32'hCAFE_0012};
    vecs[11] = '{1'b1, 32'h24, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h24, 1'b1, 32'hCAFE_0008, 1'b0, 32'hCAFE_0012};
    vecs[12] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'hCAFE_0009, 1'b0, 32'hCAFE_0012};

    // Reset state, with both requests pending during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_f_gnt",   32'(f_gnt), 32'h0);
    check("rst_d_gnt",   32'(d_gnt), 32'h0);
    check("rst_rom_ce",  32'(rom_ce), 32'h0);
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_f_valid", 32'(f_rsp_valid), 32'h0);
    check("rst_d_valid", 32'(d_rsp_valid), 32'h0);
    check("rst_f_inst",  f_rsp_inst, 32'h0);
    check("rst_d_inst",  d_rsp_inst, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;

    // Table-driven: fetch stream, flush, debug, fetch priority, lock without grant.
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].flush,
            vecs[i].d_req, vecs[i].d_addr, vecs[i].d_lock);
      @(negedge clk);
      check($sformatf("v%0d_f_gnt", i),  32'(f_gnt),       32'(vecs[i].x_f_gnt));
      check($sformatf("v%0d_d_gnt", i),  32'(d_gnt),       32'(vecs[i].x_d_gnt));
      check($sformatf("v%0d_rom_ce", i), 32'(rom_ce),      32'(vecs[i].x_ce));
      check($sformatf("v%0d_rom_addr", i), rom_addr,       vecs[i].x_addr);
      check($sformatf("v%0d_f_valid", i), 32'(f_rsp_valid), 32'(vecs[i].x_fv));
      check($sformatf("v%0d_f_inst", i),  f_rsp_inst,       vecs[i].x_finst);
      check($sformatf("v%0d_d_valid", i), 32'(d_rsp_valid), 32'(vecs[i].x_dv));
      check($sformatf("v%0d_d_inst", i),  d_rsp_inst,       vecs[i].x_dinst);
    end

    // Contention: 8 fetch grants then 1 debug grant, repeating.
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0);
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      check($sformatf("cont%0d_f_gnt", k), 32'(f_gnt), 32'((k % 9) != 8));
      check($sformatf("cont%0d_d_gnt", k), 32'(d_gnt), 32'((k % 9) == 8));
      check($sformatf("cont%0d_rom_addr", k), rom_addr, ((k % 9) == 8) ? 32'h200 : 32'h100);
      check($sformatf("cont%0d_d_valid", k), 32'(d_rsp_valid), 32'((k > 0) && (((k - 1) % 9) == 8)));
      if ((k > 0) && (((k - 1) % 9) == 8))
        check($sformatf("cont%0d_d_inst", k), d_rsp_inst, 32'hCAFE_0080);
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Lock: take ownership, fetch blocked while locked and in the release cycle.
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b1);
    for (int c = 0; c < 7; c++) begin
      if (c >= 1) drive(1'b1, 32'h180, 1'b0, 1'b1, 32'h300 + 32'(c * 4), (c < 5));
      @(negedge clk);
      check($sformatf("lock%0d_f_gnt", c), 32'(f_gnt), 32'(c == 6));
      check($sformatf("lock%0d_d_gnt", c), 32'(d_gnt), 32'(c < 6));
      check($sformatf("lock%0d_rom_addr", c), rom_addr, (c < 6) ? 32'h300 + 32'(c * 4) : 32'h180);
      if (c >= 1) begin
        check($sformatf("lock%0d_d_valid", c), 32'(d_rsp_valid), 32'h1);
        check($sformatf("lock%0d_d_inst", c), d_rsp_inst, 32'hCAFE_00C0 + 32'(c - 1));
      end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("lock_end_f_valid", 32'(f_rsp_valid), 32'h1);
    check("lock_end_f_inst",  f_rsp_inst, 32'hCAFE_0060);
    check("lock_end_d_valid", 32'(d_rsp_valid), 32'h0);

    // Asynchronous reset mid-LOCK with a debug response pending.
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h3C0, 1'b1);
    next_cycle();
    drive(1'b1, 32'h1C0, 1'b0, 1'b1, 32'h3C4, 1'b1);
    #1;
    check("pre_rst_d_valid", 32'(d_rsp_valid), 32'h1);
    check("pre_rst_f_gnt",   32'(f_gnt), 32'h0);
    rst = 1'b0;
    #1;
    check("arst_d_valid",  32'(d_rsp_valid), 32'h0);
    check("arst_f_valid",  32'(f_rsp_valid), 32'h0);
    check("arst_rom_ce",   32'(rom_ce), 32'h0);
    check("arst_rom_addr", rom_addr, 32'h0);
    check("arst_f_gnt",    32'(f_gnt), 32'h0);
    check("arst_d_gnt",    32'(d_gnt), 32'h0);
    check("arst_d_inst",   d_rsp_inst, 32'h0);
    check("arst_f_inst",   f_rsp_inst, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h1C0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    #1;
    check("post_rst_f_gnt",    32'(f_gnt), 32'h1);
    check("post_rst_rom_addr", rom_addr, 32'h1C0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("post_rst_f_valid", 32'(f_rsp_valid), 32'h1);
    check("post_rst_f_inst",  f_rsp_inst, 32'hCAFE_0070);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
